// File: rtl/sort_host_ctrl.sv
// Host-side controller for a frame sorter: buffers NUM upstream words, streams them
// into the sorter, captures the sorted stream and drains it downstream with backpressure.
module sort_host_ctrl #(
  parameter int unsigned LENGTH  = 32,
  parameter int unsigned NUM     = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LENGTH-1:0] in_data,
  output logic              in_ready,
  output logic              srt_en,
  output logic [LENGTH-1:0] srt_datain,
  input  logic [LENGTH-1:0] srt_dataout,
  input  logic              srt_over,
  input  logic              srt_write_fin,
  output logic              out_valid,
  output logic [LENGTH-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned CW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {FILL, LOAD, SORT_WAIT, CAPTURE, FIN, DRAIN} state_e;

  state_e            state_q;
  logic [CW-1:0]     slot_q;
  logic [TW-1:0]     wait_q;
  logic              srt_en_q;
  logic [LENGTH-1:0] srt_datain_q;
  logic              out_valid_q;
  logic [LENGTH-1:0] out_data_q;
  logic              out_last_q;
  logic              err_q;
  logic [15:0]       frame_cnt_q;

  logic [LENGTH-1:0] in_buf  [NUM];
  logic [LENGTH-1:0] out_buf [NUM];

  logic [CW-1:0] slot_nxt;
  logic          in_fire;
  logic          out_fire;
  logic          abort;

  // slot_q is the single frame index: write pointer in FILL, read pointer in LOAD/DRAIN,
  // capture pointer in CAPTURE.
  assign slot_nxt = slot_q + CW'(1);
  assign in_ready = (state_q == FILL);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign abort    = ((state_q == SORT_WAIT) && !srt_over && (wait_q == LAST_WAIT)) ||
                    ((state_q == FIN) && !srt_write_fin);

  // NOTE: the frame buffers carry no reset; a frame interrupted by reset is discarded
  // anyway, and leaving memories unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (in_fire) in_buf[slot_q] <= in_data;
    if (state_q == CAPTURE) out_buf[slot_q] <= srt_dataout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      slot_q       <= '0;
      wait_q       <= '0;
      srt_en_q     <= 1'b0;
      srt_datain_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= '0;
    end else if (abort) begin
      err_q    <= 1'b1;
      srt_en_q <= 1'b0;
      slot_q   <= '0;
      wait_q   <= '0;
      state_q  <= FILL;
    end else begin
      case (state_q)
        FILL: if (in_fire) begin
          if (slot_q == LAST_SLOT) begin
            // Word 0 goes out on this edge so LOAD cycle 0 already presents it.
            state_q      <= LOAD;
            slot_q       <= '0;
            srt_en_q     <= 1'b1;
            srt_datain_q <= in_buf[0];
          end else begin
            slot_q <= slot_nxt;
          end
        end
        LOAD: begin
          if (slot_q == LAST_SLOT) begin
            state_q <= SORT_WAIT;
            slot_q  <= '0;
            wait_q  <= '0;
          end else begin
            srt_datain_q <= in_buf[slot_nxt];
            slot_q       <= slot_nxt;
          end
        end
        SORT_WAIT: begin
          if (srt_over) begin
            state_q <= CAPTURE;
            slot_q  <= '0;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        CAPTURE: begin
          if (slot_q == LAST_SLOT) begin
            // Drop enable with the last sample so the sorter does not start again.
            state_q  <= FIN;
            slot_q   <= '0;
            srt_en_q <= 1'b0;
          end else begin
            slot_q <= slot_nxt;
          end
        end
        FIN: begin
          state_q     <= DRAIN;
          out_valid_q <= 1'b1;
          out_data_q  <= out_buf[0];
          out_last_q  <= 1'b0;
        end
        DRAIN: if (out_fire) begin
          if (slot_q == LAST_SLOT) begin
            state_q     <= FILL;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else begin
            slot_q     <= slot_nxt;
            out_data_q <= out_buf[slot_nxt];
            out_last_q <= (slot_nxt == LAST_SLOT);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign srt_en     = srt_en_q;
  assign srt_datain = srt_datain_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign err        = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sort_host_ctrl.sv
// Directed bench for sort_host_ctrl: a reactive sorter model plus per-scenario tasks
// covering normal frames, backpressure, timeout, missing finish, reset and back-to-back frames.
module tb_sort_host_ctrl;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        srt_en;
  logic [31:0] srt_datain;
  logic [31:0] srt_dataout = '0;
  logic        srt_over = 1'b0;
  logic        srt_write_fin = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        err;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] up_w     [N];
  logic [31:0] exp_w    [N];
  logic [31:0] m_buf    [N];
  logic [31:0] m_sorted [N];
  bit no_over = 0;
  bit no_fin  = 0;
  bit spur    = 0;

  typedef enum int {M_IDLE, M_COLLECT, M_DELAY, M_STREAM, M_FIN} m_state_e;
  m_state_e m_st = M_IDLE;
  int       m_cnt = 0;

  sort_host_ctrl #(.LENGTH(32), .NUM(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .srt_en(srt_en), .srt_datain(srt_datain), .srt_dataout(srt_dataout),
    .srt_over(srt_over), .srt_write_fin(srt_write_fin),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .err(err), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sorter model: collects 16 enabled words, pulses done 3 cycles into the wait,
  // streams the ascending result, then pulses write-finish.
  always @(negedge clk) begin
    logic [31:0] t;
    srt_over      = 1'b0;
    srt_write_fin = 1'b0;
    if (rst !== 1'b1) begin
      m_st  = M_IDLE;
      m_cnt = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (srt_en === 1'b1) begin
            m_buf[0] = srt_datain;
            m_cnt    = 1;
            m_st     = M_COLLECT;
          end else if (spur) begin
            srt_over      = 1'b1;
            srt_write_fin = 1'b1;
          end
        end
        M_COLLECT: begin
          m_buf[m_cnt] = srt_datain;
          m_cnt++;
          if (m_cnt == N) begin
            for (int i = 0; i < N; i++) m_sorted[i] = m_buf[i];
            for (int i = 0; i < N - 1; i++)
              for (int j = 0; j < N - 1 - i; j++)
                if (m_sorted[j] > m_sorted[j+1]) begin
                  t             = m_sorted[j];
                  m_sorted[j]   = m_sorted[j+1];
                  m_sorted[j+1] = t;
                end
            m_cnt = 0;
            m_st  = M_DELAY;
          end
        end
        M_DELAY: begin
          if (srt_en !== 1'b1) m_st = M_IDLE;
          else if (!no_over) begin
            if (m_cnt == 3) begin
              srt_over = 1'b1;
              m_cnt    = 0;
              m_st     = M_STREAM;
            end else m_cnt++;
          end
        end
        M_STREAM: begin
          srt_dataout = m_sorted[m_cnt];
          m_cnt++;
          if (m_cnt == N) m_st = M_FIN;
        end
        M_FIN: begin
          if (!no_fin) srt_write_fin = 1'b1;
          m_st = M_IDLE;
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input bit hold);
    int g;
    for (int i = 0; i < N; i++) begin
      g = 0;
      in_valid = 1'b1;
      in_data  = up_w[i];
      while (in_ready !== 1'b1 && g < 300) begin
        @(negedge clk);
        g++;
      end
      if (g >= 300) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: word %0d not accepted within 300 cycles", i);
      end
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Receives one frame against exp_w; stall=1 applies the ready pattern 1,0,0,...
  task automatic collect_frame(input bit stall, input string tag);
    int idx = 0;
    int cyc = 0;
    int bad_rdy = 0;
    bit first = 1;
    bit stalled = 0;
    logic prev_en = 1'b1;
    logic [31:0] held = '0;
    while (idx < N && cyc < 600) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (in_ready !== 1'b0) bad_rdy++;
      if (out_valid === 1'b1) begin
        if (first) begin
          first = 0;
          n_cmp++;
          if (prev_en !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_fin_en: srt_en in FIN got %b expected 0", tag, prev_en);
          end
        end
        if (stalled) begin
          n_cmp++;
          if (out_data !== held) begin
            n_bad++;
            $display("FAIL %s_stable: out_data got %0h expected %0h", tag, out_data, held);
          end
        end
        if (out_ready) begin
          n_cmp++;
          if (out_data !== exp_w[idx] || out_last !== (idx == N - 1)) begin
            n_bad++;
            $display("FAIL %s_word%0d: got data %0h last %b expected data %0h last %b",
                     tag, idx, out_data, out_last, exp_w[idx], (idx == N - 1));
          end
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = out_data;
        end
      end
      prev_en = srt_en;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (idx != N) begin
      n_bad++;
      $display("FAIL %s_drain_timeout: got %0d words expected %0d", tag, idx, N);
    end
    n_cmp++;
    if (bad_rdy != 0) begin
      n_bad++;
      $display("FAIL %s_in_ready: high in %0d busy cycles expected 0", tag, bad_rdy);
    end
  endtask

  task automatic check_loaded(input string tag);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (m_buf[i] !== up_w[i]) begin
        n_bad++;
        $display("FAIL %s_load%0d: srt_datain got %0h expected %0h", tag, i, m_buf[i], up_w[i]);
      end
    end
  endtask

  task automatic frame_16_down();
    for (int i = 0; i < N; i++) begin
      up_w[i]  = 32'(16 - i);
      exp_w[i] = 32'(i + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({srt_en, out_valid, out_last, err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: en/valid/last/err got %b expected 0000",
               {srt_en, out_valid, out_last, err});
    end
    n_cmp++;
    if (srt_datain !== '0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: datain %0h out_data %0h expected 0 0", srt_datain, out_data);
    end
    n_cmp++;
    if (frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_ignored_pulses();
    spur = 1;
    repeat (4) @(negedge clk);
    spur = 0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, srt_en, out_valid, err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL ignored_pulses: ready/en/valid/err got %b expected 1000",
               {in_ready, srt_en, out_valid, err});
    end
  endtask

  task automatic test_basic_frame();
    frame_16_down();
    send_frame(0);
    collect_frame(0, "basic");
    check_loaded("basic");
    n_cmp++;
    if (frame_cnt !== 16'd1 || err !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_end: frame_cnt %0d err %b valid %b expected 1 0 0",
               frame_cnt, err, out_valid);
    end
  endtask

  task automatic test_backpressure();
    up_w  = '{100, 3, 57, 12, 99, 0, 41, 8, 76, 23, 64, 5, 90, 31, 18, 47};
    exp_w = '{0, 3, 5, 8, 12, 18, 23, 31, 41, 47, 57, 64, 76, 90, 99, 100};
    send_frame(0);
    collect_frame(1, "bp");
    n_cmp++;
    if (frame_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL bp_frame_cnt: got %0d expected 2", frame_cnt);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    frame_16_down();
    no_over = 1;
    send_frame(0);
    while (err !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    no_over = 0;
    n_cmp++;
    if (n != 80) begin
      n_bad++;
      $display("FAIL timeout_latency: err after %0d cycles expected 80", n);
    end
    n_cmp++;
    if ({srt_en, in_ready, out_valid} !== 3'b010) begin
      n_bad++;
      $display("FAIL timeout_state: en/ready/valid got %b expected 010",
               {srt_en, in_ready, out_valid});
    end
    send_frame(0);
    collect_frame(0, "after_to");
    n_cmp++;
    if (err !== 1'b1 || frame_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL timeout_recover: err %b frame_cnt %0d expected 1 3", err, frame_cnt);
    end
  endtask

  task automatic test_missing_fin();
    int n = 0;
    bit saw_valid = 0;
    pulse_reset();
    n_cmp++;
    if (err !== 1'b0 || frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL nofin_pre: err %b frame_cnt %0d expected 0 0", err, frame_cnt);
    end
    frame_16_down();
    no_fin = 1;
    send_frame(0);
    while (err !== 1'b1 && n < 300) begin
      if (out_valid === 1'b1) saw_valid = 1;
      @(negedge clk);
      n++;
    end
    repeat (3) begin
      if (out_valid === 1'b1) saw_valid = 1;
      @(negedge clk);
    end
    no_fin = 0;
    n_cmp++;
    if (n != 37) begin
      n_bad++;
      $display("FAIL nofin_latency: err after %0d cycles expected 37", n);
    end
    n_cmp++;
    if (saw_valid) begin
      n_bad++;
      $display("FAIL nofin_valid: out_valid seen 1 expected 0");
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        up_w[i]  = 32'(f * 16 + 16 - i);
        exp_w[i] = 32'(f * 16 + i + 1);
      end
      send_frame(1);
      if (f < 2) in_data = 32'((f + 1) * 16 + 16);
      else in_valid = 1'b0;
      collect_frame(0, "b2b");
      check_loaded("b2b");
    end
    n_cmp++;
    if (frame_cnt !== 16'd3 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: frame_cnt %0d err %b expected 3 0", frame_cnt, err);
    end
  endtask

  task automatic test_reset_mid_capture();
    frame_16_down();
    send_frame(0);
    repeat (27) @(negedge clk);
    n_cmp++;
    if (srt_en !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre: srt_en got %b expected 1", srt_en);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (srt_en !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL midrst_async: en %b valid %b frame_cnt %0d expected 0 0 0",
               srt_en, out_valid, frame_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_ready: got %b expected 1", in_ready);
    end
    send_frame(0);
    collect_frame(0, "midrst");
    n_cmp++;
    if (frame_cnt !== 16'd1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_end: frame_cnt %0d err %b expected 1 0", frame_cnt, err);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_pulses();
    test_basic_frame();
    test_backpressure();
    test_timeout();
    test_missing_fin();
    test_back_to_back();
    test_reset_mid_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
